rule110_seed_loader: RTL and testbench
======================================

RULE110_SEED_LOADER -- requirements
Module: rule110_seed_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port ena, input, 1 bit: design enable; when low, the block is frozen.
REQ-004 SHALL have port din, input, 8 bits: seed byte from the input switches.
REQ-005 SHALL have port din_valid, input, 1 bit: din holds a byte to load.
REQ-006 SHALL have port din_ready, output, 1 bit: block can accept a byte this cycle.
REQ-007 SHALL have port flush, input, 1 bit: abandon the current load and clear the seed.
REQ-008 SHALL have port rand_start, input, 1 bit: request a pseudo-random seed (used only under REQ-027).
REQ-009 SHALL have port seed, output, 256 bits: assembled generation-0 row for the rule-110 stepper.
REQ-010 SHALL have port seed_valid, output, 1 bit: seed is complete and offered downstream.
REQ-011 SHALL have port seed_ready, input, 1 bit: downstream stepper takes the seed.
REQ-012 SHALL have port fill_count, output, 6 bits: number of bytes loaded, 0..32.

Function
REQ-013 SHALL implement states IDLE, FILL, RAND and FULL.
REQ-014 SHALL drive din_ready = ena & (state is IDLE or FILL) & ~flush & ~(state is IDLE & rand_start & RULE110_SEED_LFSR_EN defined).
REQ-015 SHALL accept a byte when din_valid & din_ready, shifting it in MSB-first: seed <= {seed[247:0], din}, fill_count += 1; IDLE->FILL on the first byte.
REQ-016 SHALL move to FULL on the accept that makes fill_count 32; the first byte then sits in seed[255:248] and the last byte in seed[7:0].
REQ-017 SHALL assert seed_valid exactly while in FULL and ena is high; in FULL, din_ready = 0 and further din_valid is ignored.
REQ-018 SHALL complete the downstream transfer when seed_valid & seed_ready; on the next cycle: state IDLE, fill_count 0, seed_valid 0, seed value retained.
REQ-019 SHALL hold seed_valid and seed stable in FULL until the transfer completes.
REQ-020 SHALL, while ena is low, hold all state, accept nothing, complete no transfer, and force din_valid/seed_ready to have no effect.
REQ-021 SHALL, on flush with ena high in any state: next cycle state IDLE, seed 0, fill_count 0, seed_valid 0.
REQ-022 SHALL give flush priority over a simultaneous byte accept, downstream transfer or rand_start.
REQ-023 SHALL ignore rand_start outside IDLE and when ena is low.

Reset
REQ-024 SHALL, while rst_n is low at a clock edge: state IDLE, seed 0, fill_count 0, seed_valid 0, din_ready 0, LFSR 16'hACE1.
REQ-025 SHALL let a reset mid-FILL, mid-RAND or in FULL discard the partial or offered seed with no transfer.
REQ-026 SHALL present din_ready = 1 in the first cycle after reset release when ena is high and flush is low.

Configuration
REQ-027 SHALL, with macro RULE110_SEED_LFSR_EN defined, go IDLE->RAND on rand_start (winning over a same-cycle din_valid); each RAND cycle shifts seed <= {seed[239:0], lfsr} and fill_count += 2; the block goes to FULL after 16 words.
REQ-028 SHALL use a 16-bit Fibonacci LFSR, lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; it advances only in RAND cycles with ena high, after its word is used, and is not re-seeded between loads.
REQ-029 SHALL, without RULE110_SEED_LFSR_EN, keep the rand_start port, ignore it, never enter RAND, and contain no LFSR logic.

Verification
REQ-030 SHALL cover: reset, then 32 bytes 0x00..0x1F with din_valid held -> seed_valid after the 32nd accept, seed[255:248]=0x00, seed[7:0]=0x1F, fill_count=32.
REQ-031 SHALL cover: FULL with seed_ready low for 10 cycles, then high -> seed stable and seed_valid high throughout; one cycle after the transfer: IDLE, fill_count 0, din_ready 1.
REQ-032 SHALL cover: 5 bytes loaded, then flush together with din_valid -> byte not taken; next cycle seed=0, fill_count=0.
REQ-033 SHALL cover: ena low for 4 cycles mid-FILL with din_valid high -> fill_count unchanged and din_ready 0; the load resumes when ena returns.
REQ-034 SHALL cover: rst_n low during FULL -> seed_valid 0 and seed 0 on the next cycle, with seed_ready never observed.
REQ-035 SHALL cover, with RULE110_SEED_LFSR_EN: rand_start after reset -> FULL after 16 cycles with seed[255:240]=16'hACE1 and seed[239:224]=16'h59C3; without the macro, rand_start leaves the block in IDLE.

Source files
------------

// File: rtl/rule110_seed_loader.sv
`default_nettype none
// ============================================================================
// Module   : rule110_seed_loader
// Purpose  : Assembles a 256-bit generation-0 row for a rule-110 stepper,
//            either from 32 seed bytes shifted in MSB-first or, optionally,
//            from 16 words of a 16-bit Fibonacci LFSR. The finished row is
//            offered downstream with a valid/ready handshake.
// Config   : RULE110_SEED_LFSR_EN - when defined, enables the pseudo-random
//            fill path (RAND state and LFSR). Undefined by default, in which
//            case rand_start is accepted but has no effect.
// Revision : 1.0 - initial release
// ============================================================================
module rule110_seed_loader (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ena,
   input  logic [7:0]   din,
   input  logic         din_valid,
   output logic         din_ready,
   input  logic         flush,
   input  logic         rand_start,
   output logic [255:0] seed,
   output logic         seed_valid,
   input  logic         seed_ready,
   output logic [5:0]   fill_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RAND = 2'd2,
      FULL = 2'd3
   } state_t;

   localparam logic [5:0] BYTES_PER_SEED = 6'd32;
   localparam logic [5:0] LAST_BYTE_CNT  = BYTES_PER_SEED - 6'd1;

   state_t         state_q,      state_d;
   logic [255:0]   seed_q,       seed_d;
   logic [5:0]     fill_count_q, fill_count_d;

   logic           rand_go_w;
   logic           accept_w;
   logic           xfer_w;

`ifdef RULE110_SEED_LFSR_EN
   localparam logic [15:0] LFSR_SEED     = 16'hACE1;
   localparam logic [5:0]  LAST_WORD_CNT = BYTES_PER_SEED - 6'd2;

   logic [15:0]    lfsr_q, lfsr_d;
   logic           lfsr_fb_w;

   // Taps 16,14,13,11 give a maximal-length sequence.
   assign lfsr_fb_w = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // A random request only counts when the loader is idle.
   assign rand_go_w = (state_q == IDLE) & rand_start;
`else
   logic           unused_rand_start;

   // Port is kept for pin compatibility; the random path is not built.
   assign unused_rand_start = rand_start;
   assign rand_go_w         = 1'b0;
`endif

   // Byte intake is open only in IDLE/FILL, never during flush, and never
   // when a random load is about to win the cycle. Held low during reset.
   assign din_ready = rst_n & ena & ~flush
                    & ((state_q == IDLE) | (state_q == FILL))
                    & ~rand_go_w;

   assign seed_valid = ena & (state_q == FULL);

   assign accept_w = din_valid & din_ready;
   assign xfer_w   = seed_valid & seed_ready;

   assign seed       = seed_q;
   assign fill_count = fill_count_q;

   // Next-state and datapath: flush wins over every other activity; with ena
   // low nothing changes at all.
   always_comb begin
      state_d      = state_q;
      seed_d       = seed_q;
      fill_count_d = fill_count_q;
`ifdef RULE110_SEED_LFSR_EN
      lfsr_d       = lfsr_q;
`endif

      if (ena) begin
         if (flush) begin
            state_d      = IDLE;
            seed_d       = '0;
            fill_count_d = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rand_go_w) begin
                     state_d = RAND;
                  end else if (accept_w) begin
                     seed_d       = {seed_q[247:0], din};
                     fill_count_d = fill_count_q + 6'd1;
                     state_d      = FILL;
                  end
               end

               FILL: begin
                  if (accept_w) begin
                     seed_d       = {seed_q[247:0], din};
                     fill_count_d = fill_count_q + 6'd1;
                     if (fill_count_q == LAST_BYTE_CNT) begin
                        state_d = FULL;
                     end
                  end
               end

               RAND: begin
`ifdef RULE110_SEED_LFSR_EN
                  // Current word is consumed first, then the LFSR steps.
                  seed_d       = {seed_q[239:0], lfsr_q};
                  fill_count_d = fill_count_q + 6'd2;
                  lfsr_d       = {lfsr_q[14:0], lfsr_fb_w};
                  if (fill_count_q == LAST_WORD_CNT) begin
                     state_d = FULL;
                  end
`else
                  // Unreachable without the random path; recover to IDLE.
                  state_d      = IDLE;
                  fill_count_d = '0;
`endif
               end

               FULL: begin
                  // Seed value is kept after hand-off; only the count clears.
                  if (xfer_w) begin
                     state_d      = IDLE;
                     fill_count_d = '0;
                  end
               end

               default: begin
                  state_d      = IDLE;
                  fill_count_d = '0;
               end
            endcase
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         seed_q       <= '0;
         fill_count_q <= '0;
      end else begin
         state_q      <= state_d;
         seed_q       <= seed_d;
         fill_count_q <= fill_count_d;
      end
   end

`ifdef RULE110_SEED_LFSR_EN
   // LFSR register; reseeded only by reset, free across successive loads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rule110_seed_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rule110_seed_loader
// Purpose  : Directed self-checking bench for rule110_seed_loader. Build with
//            RULE110_SEED_LFSR_EN defined to exercise the random fill path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rule110_seed_loader;

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic [7:0]   din;
   logic         din_valid;
   logic         din_ready;
   logic         flush;
   logic         rand_start;
   logic [255:0] seed;
   logic         seed_valid;
   logic         seed_ready;
   logic [5:0]   fill_count;

   int           pass_count;
   int           check_count;
   logic [255:0] exp_seed;

   rule110_seed_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .flush      (flush),
      .rand_start (rand_start),
      .seed       (seed),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready),
      .fill_count (fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs are then driven 1 time unit later and
   // outputs are sampled 1 more unit after that, well clear of the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      ena        = 1'b1;
      din        = 8'h00;
      din_valid  = 1'b0;
      flush      = 1'b0;
      rand_start = 1'b0;
      seed_ready = 1'b0;
      step();
      step();
      settle();
      check_count++;
      if (seed !== 256'd0 || fill_count !== 6'd0 || seed_valid !== 1'b0)
         $display("FAIL reset_state: seed=%h fill_count=%0d seed_valid=%b, required seed=0 fill_count=0 seed_valid=0",
                  seed, fill_count, seed_valid);
      else pass_count++;
      check_count++;
      if (din_ready !== 1'b0)
         $display("FAIL reset_din_ready: got %b required 0", din_ready);
      else pass_count++;
      rst_n = 1'b1;
      settle();
      check_count++;
      if (din_ready !== 1'b1)
         $display("FAIL release_din_ready: got %b required 1", din_ready);
      else pass_count++;
   endtask

   task automatic test_fill();
      exp_seed  = '0;
      din_valid = 1'b1;
      for (int i = 0; i < 32; i++) begin
         din = 8'(i);
         exp_seed = {exp_seed[247:0], 8'(i)};
         settle();
         if (i == 0 || i == 31) begin
            check_count++;
            if (din_ready !== 1'b1)
               $display("FAIL fill_ready_byte%0d: got %b required 1", i, din_ready);
            else pass_count++;
         end
         if (i == 31) begin
            check_count++;
            if (seed_valid !== 1'b0 || fill_count !== 6'd31)
               $display("FAIL fill_before_last: seed_valid=%b fill_count=%0d, required 0 and 31",
                        seed_valid, fill_count);
            else pass_count++;
         end
         step();
      end
      din = 8'hAA;
      settle();
      check_count++;
      if (seed_valid !== 1'b1 || fill_count !== 6'd32)
         $display("FAIL fill_full: seed_valid=%b fill_count=%0d, required 1 and 32",
                  seed_valid, fill_count);
      else pass_count++;
      check_count++;
      if (seed[255:248] !== 8'h00 || seed[7:0] !== 8'h1F || seed !== exp_seed)
         $display("FAIL fill_seed: got %h required %h", seed, exp_seed);
      else pass_count++;
      check_count++;
      if (din_ready !== 1'b0)
         $display("FAIL full_din_ready: got %b required 0", din_ready);
      else pass_count++;
      step();
      check_count++;
      if (seed !== exp_seed || fill_count !== 6'd32)
         $display("FAIL full_ignores_din: seed=%h fill_count=%0d, required %h and 32",
                  seed, fill_count, exp_seed);
      else pass_count++;
      din_valid = 1'b0;
   endtask

   task automatic test_hold_transfer();
      seed_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         check_count++;
         if (seed_valid !== 1'b1 || seed !== exp_seed)
            $display("FAIL hold_cycle%0d: seed_valid=%b seed=%h, required 1 and %h",
                     c, seed_valid, seed, exp_seed);
         else pass_count++;
      end
      seed_ready = 1'b1;
      step();
      seed_ready = 1'b0;
      settle();
      check_count++;
      if (seed_valid !== 1'b0 || fill_count !== 6'd0 || din_ready !== 1'b1)
         $display("FAIL after_xfer: seed_valid=%b fill_count=%0d din_ready=%b, required 0 0 1",
                  seed_valid, fill_count, din_ready);
      else pass_count++;
      check_count++;
      if (seed !== exp_seed)
         $display("FAIL xfer_seed_retained: got %h required %h", seed, exp_seed);
      else pass_count++;
   endtask

   task automatic test_flush();
      din_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = 8'hA0 + 8'(i);
         exp_seed = {exp_seed[247:0], 8'hA0 + 8'(i)};
         step();
      end
      settle();
      check_count++;
      if (fill_count !== 6'd5 || seed !== exp_seed)
         $display("FAIL flush_preload: fill_count=%0d seed=%h, required 5 and %h",
                  fill_count, seed, exp_seed);
      else pass_count++;
      flush = 1'b1;
      din   = 8'hFF;
      settle();
      check_count++;
      if (din_ready !== 1'b0)
         $display("FAIL flush_din_ready: got %b required 0", din_ready);
      else pass_count++;
      step();
      flush     = 1'b0;
      din_valid = 1'b0;
      settle();
      check_count++;
      if (seed !== 256'd0 || fill_count !== 6'd0 || seed_valid !== 1'b0)
         $display("FAIL flush_clear: seed=%h fill_count=%0d seed_valid=%b, required 0 0 0",
                  seed, fill_count, seed_valid);
      else pass_count++;
   endtask

   task automatic test_ena_freeze();
      exp_seed  = '0;
      din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = 8'h11 + 8'(i);
         exp_seed = {exp_seed[247:0], 8'h11 + 8'(i)};
         step();
      end
      ena = 1'b0;
      din = 8'h55;
      for (int c = 0; c < 4; c++) begin
         settle();
         check_count++;
         if (din_ready !== 1'b0)
            $display("FAIL freeze_din_ready%0d: got %b required 0", c, din_ready);
         else pass_count++;
         step();
         check_count++;
         if (fill_count !== 6'd3 || seed !== exp_seed)
            $display("FAIL freeze_hold%0d: fill_count=%0d seed=%h, required 3 and %h",
                     c, fill_count, seed, exp_seed);
         else pass_count++;
      end
      ena = 1'b1;
      for (int i = 3; i < 32; i++) begin
         din = 8'h40 + 8'(i);
         exp_seed = {exp_seed[247:0], 8'h40 + 8'(i)};
         step();
      end
      din_valid = 1'b0;
      settle();
      check_count++;
      if (seed_valid !== 1'b1 || fill_count !== 6'd32 || seed !== exp_seed)
         $display("FAIL resume_full: seed_valid=%b fill_count=%0d seed=%h, required 1 32 %h",
                  seed_valid, fill_count, seed, exp_seed);
      else pass_count++;
      ena        = 1'b0;
      seed_ready = 1'b1;
      settle();
      check_count++;
      if (seed_valid !== 1'b0)
         $display("FAIL freeze_full_valid: got %b required 0", seed_valid);
      else pass_count++;
      step();
      ena        = 1'b1;
      seed_ready = 1'b0;
      settle();
      check_count++;
      if (seed_valid !== 1'b1 || fill_count !== 6'd32)
         $display("FAIL freeze_no_xfer: seed_valid=%b fill_count=%0d, required 1 and 32",
                  seed_valid, fill_count);
      else pass_count++;
   endtask

   task automatic test_reset_in_full();
      seed_ready = 1'b0;
      rst_n      = 1'b0;
      step();
      rst_n = 1'b1;
      settle();
      check_count++;
      if (seed_valid !== 1'b0 || seed !== 256'd0 || fill_count !== 6'd0)
         $display("FAIL reset_in_full: seed_valid=%b seed=%h fill_count=%0d, required 0 0 0",
                  seed_valid, seed, fill_count);
      else pass_count++;
      check_count++;
      if (din_ready !== 1'b1)
         $display("FAIL reset_in_full_ready: got %b required 1", din_ready);
      else pass_count++;
   endtask

   task automatic test_rand();
      rand_start = 1'b1;
`ifdef RULE110_SEED_LFSR_EN
      din_valid = 1'b1;
      din       = 8'h77;
      settle();
      check_count++;
      if (din_ready !== 1'b0)
         $display("FAIL rand_din_ready: got %b required 0", din_ready);
      else pass_count++;
      step();
      rand_start = 1'b0;
      din_valid  = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c == 15) begin
            check_count++;
            if (seed_valid !== 1'b0 || fill_count !== 6'd30)
               $display("FAIL rand_early: seed_valid=%b fill_count=%0d, required 0 and 30",
                        seed_valid, fill_count);
            else pass_count++;
         end
      end
      check_count++;
      if (seed_valid !== 1'b1 || fill_count !== 6'd32)
         $display("FAIL rand_full: seed_valid=%b fill_count=%0d, required 1 and 32",
                  seed_valid, fill_count);
      else pass_count++;
      check_count++;
      if (seed[255:240] !== 16'hACE1 || seed[239:224] !== 16'h59C3)
         $display("FAIL rand_words: got %h %h required ace1 59c3",
                  seed[255:240], seed[239:224]);
      else pass_count++;
`else
      settle();
      check_count++;
      if (din_ready !== 1'b1)
         $display("FAIL rand_ignored_ready: got %b required 1", din_ready);
      else pass_count++;
      step();
      rand_start = 1'b0;
      for (int c = 0; c < 16; c++) step();
      check_count++;
      if (seed_valid !== 1'b0 || fill_count !== 6'd0 || seed !== 256'd0)
         $display("FAIL rand_ignored: seed_valid=%b fill_count=%0d seed=%h, required 0 0 0",
                  seed_valid, fill_count, seed);
      else pass_count++;
`endif
   endtask

   initial begin
      pass_count  = 0;
      check_count = 0;
      test_reset();
      test_fill();
      test_hold_transfer();
      test_flush();
      test_ena_freeze();
      test_reset_in_full();
      test_rand();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

`default_nettype wire
